// File: rtl/ddr2_host_frontend.sv
// Host-side admission front end for the DDR2 controller.
// It queues host commands and write data, and admits a block write only when the data FIFO
// has room for the whole block.
module ddr2_host_frontend #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned SZ_W      = 2,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned BEAT_UNIT = 8,
    parameter int unsigned CMD_AW    = 6,
    parameter int unsigned DATA_AW   = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2:0]                      cmd,
    input  logic [SZ_W-1:0]                 sz,
    input  logic [OP_W-1:0]                 op,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               din,
    input  logic                            din_valid,
    output logic                            notfull,
    output logic                            accept,
    output logic                            reject,
    output logic                            blk_busy,
    input  logic                            cmd_get,
    output logic [ADDR_W+3+SZ_W+OP_W-1:0]   cmd_data,
    output logic                            cmd_empty,
    output logic [CMD_AW:0]                 cmd_fill,
    input  logic                            data_get,
    output logic [DATA_W-1:0]               data_out,
    output logic                            data_empty,
    output logic [DATA_AW:0]                data_fill
);

    localparam int unsigned CmdW      = ADDR_W + 3 + SZ_W + OP_W;
    localparam int unsigned CmdDepth  = 2 ** CMD_AW;
    localparam int unsigned DataDepth = 2 ** DATA_AW;

    localparam logic [CMD_AW:0]  CmdFull  = (CMD_AW + 1)'(CmdDepth);
    localparam logic [DATA_AW:0] DataFull = (DATA_AW + 1)'(DataDepth);
    localparam logic [DATA_AW:0] BeatOne  = (DATA_AW + 1)'(1);

    localparam logic [2:0] CmdNop   = 3'b000;
    localparam logic [2:0] CmdRd    = 3'b001;
    localparam logic [2:0] CmdWr    = 3'b010;
    localparam logic [2:0] CmdBlkRd = 3'b011;
    localparam logic [2:0] CmdBlkWr = 3'b100;

    typedef enum logic {StIdle, StBlkWr} state_e;

    state_e             state_q;
    logic [DATA_AW:0]   cnt_q, blen_q, cnt_nxt;
    logic [DATA_AW:0]   blen, free;

    logic [CmdW-1:0]    cmd_mem_q [CmdDepth];
    logic [CMD_AW:0]    cmd_wptr_q, cmd_rptr_q;
    logic [DATA_W-1:0]  data_mem_q [DataDepth];
    logic [DATA_AW:0]   data_wptr_q, data_rptr_q;

    logic cmd_full, data_full, cmd_pop, data_pop, cmd_room, data_room;
    logic cmd_push, data_push, data_put, blk_start, ok;

    assign cmd_fill   = cmd_wptr_q - cmd_rptr_q;
    assign data_fill  = data_wptr_q - data_rptr_q;
    assign cmd_empty  = (cmd_fill == '0);
    assign data_empty = (data_fill == '0);
    assign cmd_full   = (cmd_fill == CmdFull);
    assign data_full  = (data_fill == DataFull);
    assign cmd_pop    = cmd_get && !cmd_empty;
    assign data_pop   = data_get && !data_empty;
    // A full command FIFO still takes a command when its head leaves in the same cycle.
    assign cmd_room   = !cmd_full || cmd_pop;
    assign data_room  = !data_full || data_pop;

    assign free    = DataFull - data_fill;
    assign blen    = (DATA_AW + 1)'((32'(sz) + 32'd1) * BEAT_UNIT);
    assign cnt_nxt = cnt_q + 1'b1;

    assign notfull  = (state_q == StIdle) && !cmd_full;
    assign blk_busy = (state_q == StBlkWr);
    assign cmd_data = cmd_empty ? '0 : cmd_mem_q[cmd_rptr_q[CMD_AW-1:0]];
    assign data_out = data_empty ? '0 : data_mem_q[data_rptr_q[DATA_AW-1:0]];
    assign data_put = data_push && data_room;

    always_comb begin
        accept    = 1'b0;
        reject    = 1'b0;
        cmd_push  = 1'b0;
        data_push = 1'b0;
        blk_start = 1'b0;
        ok        = 1'b0;
        if (reset) begin
            if (state_q == StIdle) begin
                if (cmd != CmdNop) begin
                    case (cmd)
                        CmdRd, CmdBlkRd: ok = cmd_room;
                        CmdWr:           ok = cmd_room && (free != '0);
                        CmdBlkWr:        ok = cmd_room && (free >= blen);
                        default:         ok = 1'b0;
                    endcase
                    accept    = ok;
                    reject    = !ok;
                    cmd_push  = ok;
                    data_push = ok && ((cmd == CmdWr) || (cmd == CmdBlkWr));
                    blk_start = ok && (cmd == CmdBlkWr);
                end
            end else begin
                data_push = din_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            blen_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (blk_start) begin
                        blen_q <= blen;
                        cnt_q  <= BeatOne;
                        if (blen != BeatOne) state_q <= StBlkWr;
                    end
                end
                StBlkWr: begin
                    if (din_valid) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == blen_q) state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            data_wptr_q <= '0;
            data_rptr_q <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop) cmd_rptr_q <= cmd_rptr_q + 1'b1;
            if (data_put) data_wptr_q <= data_wptr_q + 1'b1;
            if (data_pop) data_rptr_q <= data_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q[CMD_AW-1:0]] <= {addr, cmd, sz, op};
        if (data_put) data_mem_q[data_wptr_q[DATA_AW-1:0]] <= din;
    end

endmodule

// File: tb/tb_ddr2_host_frontend.sv
// Randomised and directed bench for ddr2_host_frontend.
// It checks the design cycle by cycle against a queue-based admission model.
module tb_ddr2_host_frontend;

    localparam int CW = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [2:0]    cmd;
    logic [1:0]    sz;
    logic [2:0]    op;
    logic [24:0]   addr;
    logic [15:0]   din;
    logic          din_valid, cmd_get, data_get;
    logic          notfull, accept, reject, blk_busy, cmd_empty, data_empty;
    logic [CW-1:0] cmd_data;
    logic [6:0]    cmd_fill, data_fill;
    logic [15:0]   data_out;

    ddr2_host_frontend dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .sz        (sz),
        .op        (op),
        .addr      (addr),
        .din       (din),
        .din_valid (din_valid),
        .notfull   (notfull),
        .accept    (accept),
        .reject    (reject),
        .blk_busy  (blk_busy),
        .cmd_get   (cmd_get),
        .cmd_data  (cmd_data),
        .cmd_empty (cmd_empty),
        .cmd_fill  (cmd_fill),
        .data_get  (data_get),
        .data_out  (data_out),
        .data_empty(data_empty),
        .data_fill (data_fill)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as queues, block progress as beats still owed.
    logic [CW-1:0] cq[$];
    logic [15:0]   dq[$];
    int            beats_left = 0;

    task automatic set_idle();
        cmd = 3'd0; sz = 2'd0; op = 3'd0; addr = '0; din = '0;
        din_valid = 1'b0; cmd_get = 1'b0; data_get = 1'b0;
    endtask

    task automatic tick();
        int csz, dsz, free, blen;
        bit idle, cpop, dpop, croom, ok, e_acc, e_rej, rs, dv;
        logic [2:0] c; logic [1:0] s; logic [2:0] o; logic [24:0] a; logic [15:0] d;
        #1;
        rs = reset; c = cmd; s = sz; o = op; a = addr; d = din; dv = din_valid;
        csz = cq.size(); dsz = dq.size();
        idle  = (beats_left == 0);
        cpop  = cmd_get && csz > 0;
        dpop  = data_get && dsz > 0;
        croom = (csz < 64) || cpop;
        free  = 64 - dsz;
        blen  = (int'(s) + 1) * 8;
        ok = 0; e_acc = 0; e_rej = 0;
        if (idle && c != 3'd0) begin
            case (c)
                3'd1, 3'd3: ok = croom;
                3'd2:       ok = croom && free >= 1;
                3'd4:       ok = croom && free >= blen;
                default:    ok = 0;
            endcase
            e_acc = ok; e_rej = !ok;
        end
        if (rs) begin
            check("accept", accept, e_acc);
            check("reject", reject, e_rej);
            check("notfull", notfull, idle && csz < 64);
            check("blk_busy", blk_busy, !idle);
            check("cmd_fill", cmd_fill, csz);
            check("data_fill", data_fill, dsz);
            check("cmd_empty", cmd_empty, csz == 0);
            check("data_empty", data_empty, dsz == 0);
            check("cmd_data", cmd_data, csz > 0 ? cq[0] : '0);
            check("data_out", data_out, dsz > 0 ? dq[0] : '0);
            if (!idle && dv) check("blk_no_overflow", data_fill < 7'd64, 1);
        end
        @(posedge clk);
        if (!rs) begin
            cq.delete(); dq.delete(); beats_left = 0;
        end else begin
            if (cpop) void'(cq.pop_front());
            if (dpop) void'(dq.pop_front());
            if (e_acc) begin
                cq.push_back({a, c, s, o});
                if (c == 3'd2 || c == 3'd4) dq.push_back(d);
                if (c == 3'd4) beats_left = blen - 1;
            end else if (!idle && dv) begin
                dq.push_back(d);
                beats_left--;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        set_idle();
        cmd_get = 1'b1; data_get = 1'b1; din_valid = 1'b1;
        while ((cq.size() > 0 || dq.size() > 0 || beats_left > 0) && n < 300) begin
            din = 16'($urandom);
            tick();
            n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
        set_idle();
    endtask

    int busy;
    int r;

    initial begin
        set_idle();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Scalar mix
        cmd = 3'd2; addr = 25'h10; din = 16'hBEEF; sz = 2'd1; op = 3'd5; tick();
        cmd = 3'd1; addr = 25'h20; tick();
        cmd = 3'd0; tick();
        check("mix_cmd_fill", cmd_fill, 2);
        check("mix_data_fill", data_fill, 1);
        check("mix_data_out", data_out, 16'hBEEF);
        check("mix_head", cmd_data, {25'h10, 3'b010, 2'd1, 3'd5});
        drain();

        // Block write of 32 beats with four stalls
        cmd = 3'd4; sz = 2'd3; addr = 25'($urandom); din = 16'($urandom); tick();
        cmd = 3'd0; busy = 0;
        for (int i = 0; i < 35; i++) begin
            if (blk_busy) busy++;
            din = 16'($urandom);
            din_valid = !(i == 3 || i == 10 || i == 18 || i == 27);
            tick();
        end
        din_valid = 1'b0;
        check("blk_busy_cycles", busy, 35);
        check("blk_notfull_after", notfull, 1);
        check("blk_beats", data_fill, 32);
        drain();

        // Reservation
        for (int i = 0; i < 40; i++) begin
            cmd = 3'd2; addr = 25'(i); din = 16'($urandom); tick();
        end
        cmd = 3'd4; sz = 2'd3; #1;
        check("rsv_reject", reject, 1);
        tick();
        cmd = 3'd0; data_get = 1'b1;
        repeat (8) tick();
        data_get = 1'b0;
        cmd = 3'd4; sz = 2'd3; addr = 25'h1234; #1;
        check("rsv_accept", accept, 1);
        tick();
        cmd = 3'd0; din_valid = 1'b1;
        repeat (31) begin din = 16'($urandom); tick(); end
        din_valid = 1'b0;
        check("rsv_fill", data_fill, 64);
        drain();

        // Full command FIFO
        for (int i = 0; i < 64; i++) begin
            cmd = 3'd1; addr = 25'(i); tick();
        end
        cmd = 3'd1; addr = 25'h777; #1;
        check("full_notfull", notfull, 0);
        check("full_reject", reject, 1);
        tick();
        cmd_get = 1'b1; #1;
        check("full_get_accept", accept, 1);
        tick();
        set_idle();
        check("full_fill_stays", cmd_fill, 64);
        drain();

        // Reserved opcode and NOP
        cmd = 3'd6; #1;
        check("reserved_reject", reject, 1);
        tick();
        cmd = 3'd0; #1;
        check("nop_no_strobe", {accept, reject}, 2'b00);
        tick();
        check("reserved_no_push", cmd_fill, 0);

        // Reset in the middle of a block write
        cmd = 3'd4; sz = 2'd1; din = 16'h5555; tick();
        cmd = 3'd0; din_valid = 1'b1;
        repeat (4) begin din = 16'($urandom); tick(); end
        din_valid = 1'b0; reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("rst_blk_busy", blk_busy, 0);
        check("rst_data_fill", data_fill, 0);
        check("rst_cmd_fill", cmd_fill, 0);
        check("rst_cmd_empty", cmd_empty, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    cmd = 3'd0;
                2:       cmd = 3'd1;
                3, 8:    cmd = 3'd2;
                4:       cmd = 3'd3;
                5, 6:    cmd = 3'd4;
                7:       cmd = 3'($urandom_range(5, 7));
                default: cmd = 3'($urandom_range(1, 2));
            endcase
            sz        = 2'($urandom);
            op        = 3'($urandom);
            addr      = 25'($urandom);
            din       = 16'($urandom);
            din_valid = $urandom_range(0, 3) != 0;
            cmd_get   = $urandom_range(0, 2) == 0;
            data_get  = $urandom_range(0, 1) == 1;
            reset     = $urandom_range(0, 599) != 0;
            tick();
        end
        reset = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
